// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: funct3 access widths,
// the LSU handshake FSM states and the byte-enable constants.
package mem_stage_lsu_pkg;

    // funct3 encodings of the RV32I load/store widths
    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } memWidth_t;

    // Request/grant/response handshake states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsuState_t;

    // Access size derived from funct3; unlisted codes behave as a word
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } accessSize_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic accessSize_t access_size(input logic [2:0] funct3);
        accessSize_t size;
        case (funct3)
            MW_B, MW_BU: size = SZ_BYTE;
            MW_H, MW_HU: size = SZ_HALF;
            default:     size = SZ_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it according to funct3.
module load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension; halfwords only look at offset[1]
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        result   = rdata;
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            MW_B:    result = {{24{byte_sel[7]}}, byte_sel};
            MW_BU:   result = {24'h000000, byte_sel};
            MW_H:    result = {{16{half_sel[15]}}, half_sel};
            MW_HU:   result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory request/grant/response
// handshake, formats store lanes and load results, and stalls the pipeline
// until the access completes.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently dropping the offending offset bits.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  readMemory_MEM,
    input  logic                  writeMemory_MEM,
    input  logic [2:0]            funct3_MEM,
    input  logic [ADDR_WIDTH-1:0] aluResult_MEM,
    input  logic [31:0]           r2Data_MEM,
    output logic                  dmemReq,
    output logic                  dmemWe,
    output logic [ADDR_WIDTH-1:0] dmemAddr,
    output logic [3:0]            dmemBe,
    output logic [31:0]           dmemWdata,
    input  logic                  dmemGnt,
    input  logic                  dmemRvalid,
    input  logic [31:0]           dmemRdata,
    output logic                  memStall,
    output logic [31:0]           loadData_MEM,
    output logic                  loadValid_MEM,
    output logic                  misalignTrap_MEM
);

    lsuState_t   state_q;
    lsuState_t   state_d;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    logic [31:0] load_data_q;
    logic [31:0] aligned_data;

    logic        mem_op;
    logic        is_load;
    logic        misalign;
    logic        op_pending;
    logic        req;
    logic        stall;
    logic        valid;
    logic        capture;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;

    // A load wins when both control bits are set
    assign mem_op  = readMemory_MEM | writeMemory_MEM;
    assign is_load = readMemory_MEM;

`ifdef MISALIGN_TRAP_EN
    // Misalignment check: halfwords need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        misalign = 1'b0;
        case (access_size(funct3_MEM))
            SZ_HALF: misalign = aluResult_MEM[0];
            SZ_WORD: misalign = |aluResult_MEM[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign op_pending = mem_op & ~misalign;

    // Handshake FSM: next state plus request/stall/valid controls
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        valid   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_pending) begin
                    req     = 1'b1;
                    capture = 1'b1;
                    if (dmemGnt) begin
                        if (is_load) begin
                            stall   = 1'b1;
                            state_d = WAIT;
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                req     = 1'b1;
                capture = 1'b1;
                if (dmemGnt) begin
                    if (is_load) begin
                        stall   = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmemRvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d = IDLE;
            req     = 1'b0;
            stall   = 1'b0;
            valid   = 1'b0;
            capture = 1'b0;
        end
    end

    // Store lane formatting; loads always enable the whole word
    always_comb begin
        be_fmt    = BE_WORD;
        wdata_fmt = 32'h0000_0000;
        if (!is_load) begin
            case (access_size(funct3_MEM))
                SZ_BYTE: begin
                    be_fmt    = BE_BYTE << aluResult_MEM[1:0];
                    wdata_fmt = {4{r2Data_MEM[7:0]}};
                end
                SZ_HALF: begin
                    be_fmt    = BE_HALF << {aluResult_MEM[1], 1'b0};
                    wdata_fmt = {2{r2Data_MEM[15:0]}};
                end
                default: begin
                    be_fmt    = BE_WORD;
                    wdata_fmt = r2Data_MEM;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata  (dmemRdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (aligned_data)
    );

    // State register, captured access attributes and the registered load result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            offset_q    <= 2'b00;
            funct3_q    <= 3'b000;
            load_data_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (capture) begin
                offset_q <= aluResult_MEM[1:0];
                funct3_q <= funct3_MEM;
            end
            if (state_q == WAIT && dmemRvalid) begin
                load_data_q <= aligned_data;
            end
        end
    end

    assign dmemReq          = req;
    assign dmemWe           = req & ~is_load;
    assign dmemAddr         = req ? {aluResult_MEM[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmemBe           = req ? be_fmt : BE_NONE;
    assign dmemWdata        = req ? wdata_fmt : 32'h0000_0000;
    assign memStall         = stall;
    assign loadValid_MEM    = valid;
    assign loadData_MEM     = reset ? 32'h0000_0000 : load_data_q;
    assign misalignTrap_MEM = ~reset & (state_q == IDLE) & mem_op & misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed scoreboard bench for mem_stage_lsu: expected bus transactions and
// load results are queued when stimulus is driven and checked when the DUT
// grants a request or presents a valid load.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        readMemory_MEM;
    logic        writeMemory_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] aluResult_MEM;
    logic [31:0] r2Data_MEM;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemBe;
    logic [31:0] dmemWdata;
    logic        dmemGnt;
    logic        dmemRvalid;
    logic [31:0] dmemRdata;
    logic        memStall;
    logic [31:0] loadData_MEM;
    logic        loadValid_MEM;
    logic        misalignTrap_MEM;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busTxn_t;

    busTxn_t     reqQ[$];
    logic [31:0] loadQ[$];
    int          vectors = 0;
    int          miscompares = 0;

    mem_stage_lsu #(.ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .readMemory_MEM   (readMemory_MEM),
        .writeMemory_MEM  (writeMemory_MEM),
        .funct3_MEM       (funct3_MEM),
        .aluResult_MEM    (aluResult_MEM),
        .r2Data_MEM       (r2Data_MEM),
        .dmemReq          (dmemReq),
        .dmemWe           (dmemWe),
        .dmemAddr         (dmemAddr),
        .dmemBe           (dmemBe),
        .dmemWdata        (dmemWdata),
        .dmemGnt          (dmemGnt),
        .dmemRvalid       (dmemRvalid),
        .dmemRdata        (dmemRdata),
        .memStall         (memStall),
        .loadData_MEM     (loadData_MEM),
        .loadValid_MEM    (loadValid_MEM),
        .misalignTrap_MEM (misalignTrap_MEM)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of pipeline and memory inputs, then let outputs settle
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic gnt, input logic rv, input logic [31:0] rdat);
        readMemory_MEM  = rd;
        writeMemory_MEM = wr;
        funct3_MEM      = f3;
        aluResult_MEM   = addr;
        r2Data_MEM      = wd;
        dmemGnt         = gnt;
        dmemRvalid      = rv;
        dmemRdata       = rdat;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectBus(input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        busTxn_t t;
        t.we    = we;
        t.addr  = addr;
        t.be    = be;
        t.wdata = wdata;
        reqQ.push_back(t);
    endtask

    // Pop the oldest expected transaction and compare it with the granted bus
    task automatic checkBus(input string tag);
        busTxn_t t;
        checkOutput({tag, "_req"}, 32'(dmemReq), 32'd1);
        checkOutput({tag, "_queued"}, 32'(reqQ.size() > 0), 32'd1);
        if (reqQ.size() > 0) begin
            t = reqQ.pop_front();
            checkOutput({tag, "_we"}, 32'(dmemWe), 32'(t.we));
            checkOutput({tag, "_addr"}, dmemAddr, t.addr);
            checkOutput({tag, "_be"}, 32'(dmemBe), 32'(t.be));
            if (t.we) checkOutput({tag, "_wdata"}, dmemWdata, t.wdata);
        end
    endtask

    task automatic checkLoad(input string tag);
        logic [31:0] exp;
        checkOutput({tag, "_valid"}, 32'(loadValid_MEM), 32'd1);
        checkOutput({tag, "_lqueued"}, 32'(loadQ.size() > 0), 32'd1);
        if (loadQ.size() > 0) begin
            exp = loadQ.pop_front();
            checkOutput({tag, "_data"}, loadData_MEM, exp);
        end
    endtask

    // Full load transaction with gntWait/rvWait idle cycles before grant/rvalid
    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input int gntWait, input int rvWait, input logic [31:0] rdat,
                          input logic [31:0] expAddr, input logic [31:0] expData,
                          input int expStalls);
        int stalls = 0;
        expectBus(1'b0, expAddr, 4'b1111, 32'h0);
        for (int i = 0; i <= gntWait; i++) begin
            if (i > 0) nextCycle();
            applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, (i == gntWait), 1'b0, 32'h0);
            checkOutput({tag, "_reqhold"}, 32'(dmemReq), 32'd1);
            checkOutput({tag, "_trap"}, 32'(misalignTrap_MEM), 32'd0);
            if (i == gntWait) checkBus(tag);
            stalls += int'(memStall);
        end
        for (int i = 0; i <= rvWait; i++) begin
            nextCycle();
            if (i == rvWait) loadQ.push_back(expData);
            applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, 1'b0, (i == rvWait), rdat);
            checkOutput({tag, "_waitreq"}, 32'(dmemReq), 32'd0);
            stalls += int'(memStall);
        end
        nextCycle();
        applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, 1'b0, 1'b0, 32'h0);
        checkLoad(tag);
        checkOutput({tag, "_donestall"}, 32'(memStall), 32'd0);
        checkOutput({tag, "_donereq"}, 32'(dmemReq), 32'd0);
        checkOutput({tag, "_stallcycles"}, 32'(stalls), 32'(expStalls));
    endtask

    task automatic idleCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Directed sequence
    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);

        // Reset state: op presented during reset produces no activity
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_req", 32'(dmemReq), 32'd0);
        checkOutput("rst_stall", 32'(memStall), 32'd0);
        checkOutput("rst_valid", 32'(loadValid_MEM), 32'd0);
        checkOutput("rst_data", loadData_MEM, 32'h0);
        checkOutput("rst_be", 32'(dmemBe), 32'd0);

        // SB to 0x103 with immediate grant
        nextCycle();
        reset = 1'b0;
        expectBus(1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5);
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1'b1, 1'b0, 32'h0);
        checkBus("sb");
        checkOutput("sb_stall", 32'(memStall), 32'd0);
        idleCycle();
        checkOutput("sb_after_req", 32'(dmemReq), 32'd0);
        checkOutput("sb_after_stall", 32'(memStall), 32'd0);

        // SH to 0x102 with one cycle of grant wait
        nextCycle();
        expectBus(1'b1, 32'h100, 4'b1100, 32'hABCDABCD);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1'b0, 1'b0, 32'h0);
        checkOutput("sh_wait_stall", 32'(memStall), 32'd1);
        checkOutput("sh_wait_req", 32'(dmemReq), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1'b1, 1'b0, 32'h0);
        checkBus("sh");
        checkOutput("sh_gnt_stall", 32'(memStall), 32'd0);
        idleCycle();
        checkOutput("sh_after_req", 32'(dmemReq), 32'd0);

        // LB 0x101: grant after 2 cycles, rvalid 3 cycles later
        nextCycle();
        doLoad("lb", 3'b000, 32'h101, 2, 2, 32'h123480FF, 32'h100, 32'hFFFFFF80, 6);
        idleCycle();
        checkOutput("lb_after_valid", 32'(loadValid_MEM), 32'd0);
        checkOutput("lb_after_data", loadData_MEM, 32'hFFFFFF80);

        // LHU / LH from 0x102
        nextCycle();
        doLoad("lhu", 3'b101, 32'h102, 0, 0, 32'hBEEF0000, 32'h100, 32'h0000BEEF, 2);
        nextCycle();
        doLoad("lh", 3'b001, 32'h102, 0, 1, 32'hBEEF0000, 32'h100, 32'hFFFFBEEF, 3);

        // LW to misaligned 0x106
        nextCycle();
`ifdef MISALIGN_TRAP_EN
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("mis_trap", 32'(misalignTrap_MEM), 32'd1);
        checkOutput("mis_req", 32'(dmemReq), 32'd0);
        checkOutput("mis_stall", 32'(memStall), 32'd0);
        checkOutput("mis_valid", 32'(loadValid_MEM), 32'd0);
        idleCycle();
        checkOutput("mis_after_req", 32'(dmemReq), 32'd0);
        checkOutput("mis_after_stall", 32'(memStall), 32'd0);
`else
        doLoad("lw_mis", 3'b010, 32'h106, 0, 0, 32'hCAFEF00D, 32'h104, 32'hCAFEF00D, 2);
`endif

        // Reset asserted in WAIT, late rvalid ignored
        nextCycle();
        expectBus(1'b0, 32'h200, 4'b1111, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        checkBus("rstw");
        checkOutput("rstw_gnt_stall", 32'(memStall), 32'd1);
        nextCycle();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("rstw_req", 32'(dmemReq), 32'd0);
        checkOutput("rstw_stall", 32'(memStall), 32'd0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("rstw_rv_stall", 32'(memStall), 32'd0);
        checkOutput("rstw_rv_req", 32'(dmemReq), 32'd0);
        idleCycle();
        checkOutput("rstw_valid", 32'(loadValid_MEM), 32'd0);
        checkOutput("rstw_data", loadData_MEM, 32'h0);
        checkOutput("rstw_stall_after", 32'(memStall), 32'd0);

        // Back-to-back SW then LW, both granted immediately
        nextCycle();
        expectBus(1'b1, 32'h300, 4'b1111, 32'h11223344);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h300, 32'h11223344, 1'b1, 1'b0, 32'h0);
        checkBus("sw");
        checkOutput("sw_stall", 32'(memStall), 32'd0);
        nextCycle();
        doLoad("lw", 3'b010, 32'h304, 0, 0, 32'h55667788, 32'h304, 32'h55667788, 2);
        idleCycle();
        checkOutput("end_sb_empty", 32'(reqQ.size() + loadQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
